// File: rtl/awg_pkg.sv
// Shared definitions for the AWG host-link front end: UART receiver state
// encoding, default link timing and the ASCII codes the command parser keys on.
package awg_pkg;

    localparam int unsigned DEF_CLK_HZ = 50_000_000;
    localparam int unsigned DEF_BAUD   = 115_200;

    // Lower-case 'f' opens a frequency command on the host link.
    localparam logic [7:0] ASCII_F = 8'h66;
    localparam logic [7:0] ASCII_0 = 8'h30;
    localparam logic [7:0] ASCII_9 = 8'h39;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_PARITY    = 3'd3,
        RX_STOP      = 3'd4,
        RX_WAIT_IDLE = 3'd5
    } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_byte_sync_2ff.sv
// Generic two-flop synchroniser for asynchronous inputs. The flops reset to
// RST_VAL so an idle-high line does not look like activity coming out of reset.
module sync_2ff #(
    parameter int                WIDTH   = 1,
    parameter logic [WIDTH-1:0]  RST_VAL = '1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // Two back-to-back flops; only r_sync is safe to use downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_rx_byte.sv
// UART byte receiver feeding the AWG command parser. Default frame is 8-N-1;
// defining UART_RX_PARITY_EN switches to 8-E-1 and enables parity_err.
// A good byte is loaded into cmd one cycle before rd pulses, so the parser
// always sees a settled cmd on the rising edge of rd.
//
// state        | meaning
// RX_IDLE      | line idle, waiting for a start edge
// RX_START     | half a bit in, confirm the start bit is still low
// RX_DATA      | sample 8 data bits LSB-first at bit centres
// RX_PARITY    | sample and check the even parity bit (parity builds only)
// RX_STOP      | sample the stop bit and report the frame outcome
// RX_WAIT_IDLE | after a framing error, wait for the line to return high
module uart_rx_byte
    import awg_pkg::*;
#(
    parameter int CLK_HZ = DEF_CLK_HZ,
    parameter int BAUD   = DEF_BAUD
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    output logic [7:0] cmd,
    output logic       rd,
    output logic       frame_err,
    output logic       parity_err
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic           w_rxs;
    uart_rx_state_t r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]     r_bit_idx;
    logic [7:0]     r_data;
    logic [7:0]     r_cmd;
    logic           r_load;
    logic           r_rd;
    logic           r_frame_err;
`ifdef UART_RX_PARITY_EN
    logic           r_par_bad;
    logic           r_parity_err;
`endif

    sync_2ff #(.WIDTH(1), .RST_VAL(1'b1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (rxd),
        .o_q   (w_rxs)
    );

    // Frame state machine, bit timing, shift register and output strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= RX_IDLE;
            r_cnt        <= '0;
            r_bit_idx    <= '0;
            r_data       <= '0;
            r_cmd        <= '0;
            r_load       <= 1'b0;
            r_rd         <= 1'b0;
            r_frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bad    <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_load      <= 1'b0;
            r_rd        <= r_load;
            r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_err <= 1'b0;
`endif
            case (r_state)
                RX_IDLE: begin
                    r_cnt <= '0;
                    if (!w_rxs) r_state <= RX_START;
                end
                RX_START: begin
                    if (r_cnt == CNT_HALF) begin
                        r_cnt     <= '0;
                        r_bit_idx <= '0;
                        r_state   <= w_rxs ? RX_IDLE : RX_DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (r_cnt == CNT_LAST) begin
                        r_cnt     <= '0;
                        r_data    <= {w_rxs, r_data[7:1]};
                        r_bit_idx <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            r_state <= RX_PARITY;
`else
                            r_state <= RX_STOP;
`endif
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                RX_PARITY: begin
                    if (r_cnt == CNT_LAST) begin
                        r_cnt     <= '0;
                        r_par_bad <= (w_rxs != (^r_data));
                        r_state   <= RX_STOP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
`endif
                RX_STOP: begin
                    if (r_cnt == CNT_LAST) begin
                        r_cnt <= '0;
                        if (w_rxs) begin
`ifdef UART_RX_PARITY_EN
                            if (r_par_bad) begin
                                r_parity_err <= 1'b1;
                            end else begin
                                r_cmd  <= r_data;
                                r_load <= 1'b1;
                            end
`else
                            r_cmd  <= r_data;
                            r_load <= 1'b1;
`endif
                            // Leave mid-stop-bit so a back-to-back start edge is caught.
                            r_state <= RX_IDLE;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= RX_WAIT_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RX_WAIT_IDLE: begin
                    if (w_rxs) r_state <= RX_IDLE;
                end
                default: r_state <= RX_IDLE;
            endcase
        end
    end

    assign cmd       = r_cmd;
    assign rd        = r_rd;
    assign frame_err = r_frame_err;
`ifdef UART_RX_PARITY_EN
    assign parity_err = r_parity_err;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: doc/uart_rx_byte.md
# uart_rx_byte

Asynchronous serial receiver that sits directly upstream of the AWG command parser. It deserialises 8-N-1 UART frames from the host link into bytes. Each good byte is presented on `cmd`, followed by a one-cycle `rd` strobe, so the parser sees exactly one rising `rd` edge per received ASCII character. Bad frames are reported on error strobes and never reach `cmd`.

## Interface
Parameters:
- `CLK_HZ`, 50_000_000, system clock frequency in Hz.
- `BAUD`, 115200, line rate. `CLKS_PER_BIT = CLK_HZ/BAUD` (integer divide, must be ≥ 8).

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `rxd`  in  1  raw serial line, idle high, asynchronous to `clk`.
- `cmd`  out  8  last good received byte.
- `rd`  out  1  one-cycle strobe; `cmd` is stable at and after its rising edge.
- `frame_err`  out  1  one-cycle strobe: stop bit sampled low.
- `parity_err`  out  1  one-cycle strobe: parity mismatch (tied 0 when parity is compiled out).

## Operation
- `rxd` passes through a 2-flop synchroniser. All further references to the line mean the synchronised value `rxs`.
- State machine states: `IDLE`, `START`, `DATA`, `PARITY`, `STOP`, `WAIT_IDLE`.
- `IDLE`: on `rxs`=0, clear the bit counter `cnt` and go to `START`.
- `START`: count to `CLKS_PER_BIT/2 - 1`, then sample.
  - `rxs`=0: go to `DATA`, clear `cnt`, clear bit index.
  - `rxs`=1: false start; return to `IDLE` with no strobe.
- `DATA`: sample on each `cnt == CLKS_PER_BIT-1`, shift into the data register LSB-first, and wrap `cnt` to 0. After bit index 7, go to `PARITY` if enabled, otherwise `STOP`.
- `PARITY`: sample one bit-period later and compare against the even parity of the 8 data bits. On mismatch, latch the error flag. Go to `STOP`.
- `STOP`: sample one bit-period later.
  - `rxs`=1 and no parity error: load `cmd` from the data register; pulse `rd` the next cycle; go to `IDLE`.
  - `rxs`=1 with parity error: pulse `parity_err`; `cmd` unchanged, no `rd`; go to `IDLE`.
  - `rxs`=0: pulse `frame_err`; `cmd` unchanged, no `rd`; go to `WAIT_IDLE`.
- `WAIT_IDLE`: stay until `rxs`=1, then go to `IDLE`. A break condition therefore produces exactly one `frame_err`.
- Counter widths: `cnt` is `$clog2(CLKS_PER_BIT)` bits; the bit index is 3 bits.
- Reset mid-frame aborts the frame immediately. No partial byte is ever delivered.

## Timing
- Reset values:
  - `cmd`=8'h00, `rd`=0, `frame_err`=0, `parity_err`=0.
  - State=`IDLE`; synchroniser flops reset to 1.
- Latency: let t0 be the first clock with `rxs`=0, i.e. 2 clocks after the `rxd` edge.
  - Stop bit is sampled at t0 + `CLKS_PER_BIT/2` + 9·`CLKS_PER_BIT`, plus `CLKS_PER_BIT` with parity.
  - `cmd` updates on the edge after the stop sample; `rd` is high for the single cycle after that.
- `rd`, `frame_err` and `parity_err` are mutually exclusive and each high for exactly 1 cycle.
- Back-to-back frames: `STOP` returns to `IDLE` mid-stop-bit, so a start edge arriving ≥ `CLKS_PER_BIT/2` clocks later is caught.
- `cmd` holds its value between strobes.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - Frame is 8-E-1; the `PARITY` state exists.
  - `parity_err` is driven as described above.
- Undefined:
  - Frame is 8-N-1; `PARITY` is removed and `DATA` goes straight to `STOP`.
  - `parity_err` is constant 0.

## Structure
- Shared package `awg_pkg`:
  - state enum `uart_rx_state_t`;
  - default `CLK_HZ`/`BAUD` constants;
  - ASCII constants used by the parser (`ASCII_F`, `ASCII_0`, `ASCII_9`).
- One sub-module, `sync_2ff`: generic 2-flop synchroniser with an async active-low reset to a parameterised value, reusable for other async inputs.

## Test plan
Bench uses `CLK_HZ`=1_000_000, `BAUD`=100_000, giving `CLKS_PER_BIT`=10.
- Single byte 0x66 ("f") → `cmd`=8'h66, exactly one `rd` pulse at the computed latency; no error strobes.
- Back-to-back "f1234" with no idle gap → five `rd` pulses carrying 0x66, 0x31, 0x32, 0x33, 0x34 in order.
- `rxd` low glitch of 3 clocks → no `rd`, no error strobe, state back to `IDLE`; next frame 0x41 received correctly.
- Frame 0x55 with stop bit low, held low 30 bit-times → one `frame_err`, `cmd` keeps its prior value; after line goes high, frame 0x39 → `rd`, `cmd`=8'h39.
- `rst_n` asserted at data bit 4 of a frame → all outputs 0 immediately, no `rd`; next full frame 0x30 received correctly.
- With `UART_RX_PARITY_EN`: 0x31 sent with wrong (odd) parity → one `parity_err`, no `rd`; 0x31 with correct parity → `rd`, `cmd`=8'h31.
